cmp_share_arbiter: RTL and testbench
====================================

# cmp_share_arbiter

Round-robin arbiter and sequencer that shares a single `eight_bit_comparator` instance among `NREQ` requesters. Each requester presents an 8-bit operand pair and raises a request. The block grants one requester per cycle, registers its operands into the shared comparator, and returns a registered less/equal/more result tagged with the requester ID. The result holds under consumer backpressure. It sits between the compare clients and the comparator datapath and is the only instantiator of the comparator in the subsystem.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `IDW`, default 2: ID width; must equal clog2(`NREQ`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  `NREQ`  per-requester compare request; level, held until granted.
- `a_bus`  in  8·`NREQ`  operand A; requester i drives bits [8i+7:8i].
- `b_bus`  in  8·`NREQ`  operand B; same packing as `a_bus`.
- `gnt`  out  `NREQ`  one-hot grant pulse, registered.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_id`  out  `IDW`  requester that owns the current result.
- `out_less`, `out_equal`, `out_more`  out  1 each  registered compare result, one-hot while `res_valid`=1.

## Operation
- Two-stage pipeline with valid bits `s1_v` (operand stage) and `res_valid` (result stage).
- Occupancy states: EMPTY (0,0), OP (1,0), RES (0,1), FULL (1,1).
- Stall rule:
  - `res_hold` = `res_valid` & ~`res_ready`.
  - `s1_stall` = `s1_v` & `res_hold`.
- Arbitration:
  - Evaluated every cycle with `s1_stall`=0.
  - Eligible set = `req` & ~`gnt`. A requester granted this cycle cannot win the next arbitration.
  - Winner = first eligible index searching upward from `ptr`+1, modulo `NREQ`.
- On a win at a clock edge:
  - `gnt`[winner]=1 for exactly one cycle.
  - Its `a`/`b` slices are captured into the operand registers; `s1_id`=winner; `s1_v`=1.
  - `ptr`=winner.
- No eligible request, or `s1_stall`=1: `gnt`=0 and the operand stage keeps its contents.
- Requesters must deassert `req` in the cycle `gnt` is high, or change operands before re-requesting. A `req` still high after the grant cycle is a new request.
- Shared comparator: combinational on the operand registers. Inputs are `a`, `b` and cascade (`1'b0`, `1'b1`, `1'b0`). Its less/equal/more outputs feed the result stage.
- Result stage loads when `s1_v`=1 and `res_hold`=0:
  - `res_valid`=1; result bits and `res_id`=`s1_id` are captured.
  - If `res_ready`=1 and `s1_v`=0, then `res_valid`→0.
- While `res_hold`=1, the result stage and all its outputs are frozen.
- A result not loaded or accepted is never dropped or duplicated.

## Timing
- Reset (async assert, sync release), all outputs and state:
  - `gnt`=0, `res_valid`=0, `res_id`=0, `out_less`=`out_equal`=`out_more`=0.
  - `s1_v`=0, `ptr`=`NREQ`-1, so requester 0 wins first.
- Latency: `req` high before edge E0 → `gnt` high after E0 → `res_valid` high after E1. Request-to-result is 2 cycles with no backpressure.
- Throughput:
  - One grant per cycle with ≥2 active requesters.
  - A single continuous requester gets one grant every 2 cycles.
- Backpressure: with FULL and `res_ready`=0, no grant is issued. The grant resumes on the cycle after `res_ready`=1 is sampled.
- Simultaneous accept and load (`res_valid`=1, `res_ready`=1, `s1_v`=1): the result is replaced in the same edge with no bubble.
- Reset mid-operation: pending operand and result contents are discarded. Requesters whose `req` is still high are re-arbitrated from `ptr`=`NREQ`-1.
- Unused requests (`req`=0) never receive `gnt`. `gnt` is always zero or one-hot.

## Configuration
- `CMP_SHARE_SIGNED_EN`:
  - Defined: bit 7 of both captured operands is inverted before the comparator, so results are two's-complement signed. Example: 8'h80 < 8'h7F → `out_less`=1.
  - Undefined: unsigned compare. Example: 8'h80 vs 8'h7F → `out_more`=1.
- No port changes in either build; latency is unchanged.

## Test plan
- Reset then idle: all outputs 0, held through 10 cycles with `req`=0.
- Single request, `NREQ`=4, `res_ready`=1: req[2] with a=8'h35, b=8'h35 → `gnt`=4'b0100 after E0. Then `res_valid`=1, `res_id`=2, `out_equal`=1 after E1 for one cycle.
- All four requesting continuously from reset → grants 0,1,2,3,0 on consecutive cycles. Results arrive in the same order, one per cycle, each ID matching its operands.
- Backpressure: 3 requests, `res_ready`=0 for 5 cycles → at most 2 grants issued and `res_valid` result frozen. Release `res_ready` → remaining results delivered in order, none lost or repeated.
- Signed build vs unsigned build: a=8'hF0, b=8'h10 → `out_less`=1 with `CMP_SHARE_SIGNED_EN`, `out_more`=1 without it.
- Assert `rst_n`=0 while FULL, release with req[1] held → `res_valid` drops immediately. First post-reset grant goes to requester 1 with 2-cycle latency.

Source files
------------

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one eight_bit_comparator among NREQ requesters.
// Optional macro CMP_SHARE_SIGNED_EN selects a two's-complement compare.

module eight_bit_comparator (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       less_i,
  input  logic       equal_i,
  input  logic       more_i,
  output logic       less_o,
  output logic       equal_o,
  output logic       more_o
);
  // Equal operands pass the cascade inputs through.
  always_comb begin
    less_o  = less_i;
    equal_o = equal_i;
    more_o  = more_i;
    if (a_i < b_i) begin
      less_o  = 1'b1;
      equal_o = 1'b0;
      more_o  = 1'b0;
    end else if (a_i > b_i) begin
      less_o  = 1'b0;
      equal_o = 1'b0;
      more_o  = 1'b1;
    end
  end
endmodule

module cmp_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] a_bus,
  input  logic [8*NREQ-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic              out_less,
  output logic              out_equal,
  output logic              out_more
);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  ptr_q;
  logic            s1_v_q, s1_v_d;
  logic [7:0]      s1_a_q, s1_b_q;
  logic [IDW-1:0]  s1_id_q;
  logic            res_valid_q, res_valid_d;
  logic [IDW-1:0]  res_id_q;
  logic            res_less_q, res_equal_q, res_more_q;

  logic            res_hold, s1_stall, res_load;
  logic [NREQ-1:0] eligible;
  logic            win;
  logic [IDW-1:0]  win_idx, cand;
  logic [7:0]      sel_a, sel_b, cmp_a, cmp_b;
  logic            cmp_less, cmp_equal, cmp_more;

  assign res_hold = res_valid_q & ~res_ready;
  assign s1_stall = s1_v_q & res_hold;
  assign res_load = s1_v_q & ~res_hold;
  // A requester granted last cycle is masked so a held req is not re-granted back to back.
  assign eligible = req & ~gnt_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!win && eligible[cand]) begin
        win     = 1'b1;
        win_idx = cand;
      end
    end
    if (s1_stall) win = 1'b0;

    gnt_d = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win && win_idx == IDW'(i)) begin
        gnt_d[i] = 1'b1;
        sel_a    = a_bus[8*i +: 8];
        sel_b    = b_bus[8*i +: 8];
      end
    end

    s1_v_d      = win | s1_stall;
    res_valid_d = res_valid_q;
    if (res_load)       res_valid_d = 1'b1;
    else if (res_ready) res_valid_d = 1'b0;
  end

`ifdef CMP_SHARE_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign cmp_a = {~s1_a_q[7], s1_a_q[6:0]};
  assign cmp_b = {~s1_b_q[7], s1_b_q[6:0]};
`else
  assign cmp_a = s1_a_q;
  assign cmp_b = s1_b_q;
`endif

  eight_bit_comparator u_cmp (
    .a_i     (cmp_a),
    .b_i     (cmp_b),
    .less_i  (1'b0),
    .equal_i (1'b1),
    .more_i  (1'b0),
    .less_o  (cmp_less),
    .equal_o (cmp_equal),
    .more_o  (cmp_more)
  );

  // NOTE: state uses non-blocking assignments; datapath registers are reset too
  // so outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      ptr_q       <= IDW'(NREQ - 1);
      s1_v_q      <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_less_q  <= 1'b0;
      res_equal_q <= 1'b0;
      res_more_q  <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      s1_v_q      <= s1_v_d;
      res_valid_q <= res_valid_d;
      if (win) begin
        ptr_q   <= win_idx;
        s1_a_q  <= sel_a;
        s1_b_q  <= sel_b;
        s1_id_q <= win_idx;
      end
      if (res_load) begin
        res_id_q    <= s1_id_q;
        res_less_q  <= cmp_less;
        res_equal_q <= cmp_equal;
        res_more_q  <= cmp_more;
      end
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign out_less  = res_less_q;
  assign out_equal = res_equal_q;
  assign out_more  = res_more_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: directed requests push expected
// results; a negedge monitor pops and compares each accepted result.

module tb_cmp_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef CMP_SHARE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] a_bus, b_bus;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [IDW-1:0]    res_id;
  logic              out_less, out_equal, out_more;
  logic [7:0]        a_v [NREQ];
  logic [7:0]        b_v [NREQ];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           l;
    logic           e;
    logic           m;
  } res_t;

  res_t exp_q[$];
  res_t mon_exp;
  int   n_vec = 0;
  int   n_err = 0;

  cmp_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .out_less  (out_less),
    .out_equal (out_equal),
    .out_more  (out_more)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_bus[8*i +: 8] = a_v[i];
      b_bus[8*i +: 8] = b_v[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t r(input int id, input bit l, input bit e, input bit m);
    res_t x;
    x.id = IDW'(id);
    x.l  = l;
    x.e  = e;
    x.m  = m;
    return x;
  endfunction

  // Monitor: every result the consumer accepts must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got id %0d lem %b%b%b with nothing expected",
                 res_id, out_less, out_equal, out_more);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {res_id, out_less, out_equal, out_more}, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_v[i] = a;
    b_v[i] = b;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = '0;
    res_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_op(i, 8'h00, 8'h00);

    // Reset then idle
    step();
    check("in_reset", {gnt, res_valid, res_id, out_less, out_equal, out_more}, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle", {gnt, res_valid, res_id, out_less, out_equal, out_more}, 0);
    end

    // Single request on requester 2, equal operands
    set_op(2, 8'h35, 8'h35);
    req = 4'b0100;
    exp_q.push_back(r(2, 0, 1, 0));
    step();
    check("single_gnt", gnt, 4'b0100);
    req = '0;
    step();
    check("single_gnt_pulse", gnt, 4'b0000);
    check("single_res_valid", res_valid, 1);
    step();
    check("single_res_one_cycle", res_valid, 0);

    // All four requesting continuously from reset
    apply_reset();
    set_op(0, 8'h10, 8'h20);
    set_op(1, 8'h30, 8'h30);
    set_op(2, 8'h90, 8'h05);
    set_op(3, 8'h80, 8'h7F);
    req = 4'b1111;
    exp_q.push_back(r(0, 1, 0, 0));
    exp_q.push_back(r(1, 0, 1, 0));
    exp_q.push_back(r(2, 0, 0, 1));
    exp_q.push_back(r(3, SGN, 0, !SGN));
    exp_q.push_back(r(0, 1, 0, 0));
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr_gnt%0d", k), gnt, 4'b0001 << (k % 4));
    end
    req = '0;
    step();
    step();
    step();
    check("rr_gnt_idle", gnt, 0);
    check("rr_drained", exp_q.size(), 0);

    // Backpressure with three requesters
    apply_reset();
    set_op(0, 8'h01, 8'h02);
    set_op(1, 8'hFF, 8'h00);
    set_op(2, 8'hAA, 8'hAA);
    req       = 4'b0111;
    res_ready = 1'b0;
    exp_q.push_back(r(0, 1, 0, 0));
    exp_q.push_back(r(1, 0, 0, 1));
    exp_q.push_back(r(2, 0, 1, 0));
    step();
    check("bp_gnt0", gnt, 4'b0001);
    req = 4'b0110;
    step();
    check("bp_gnt1", gnt, 4'b0010);
    check("bp_res", {res_valid, res_id, out_less, out_equal, out_more}, {1'b1, 2'd0, 3'b100});
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_no_gnt", gnt, 0);
      check("bp_frozen", {res_valid, res_id, out_less, out_equal, out_more}, {1'b1, 2'd0, 3'b100});
    end
    res_ready = 1'b1;
    step();
    check("bp_resume_gnt", gnt, 4'b0100);
    req = '0;
    step();
    check("bp_gnt_done", gnt, 0);
    step();
    check("bp_res_cleared", res_valid, 0);
    check("bp_drained", exp_q.size(), 0);

    // Signed versus unsigned compare
    apply_reset();
    set_op(3, 8'hF0, 8'h10);
    req = 4'b1000;
    exp_q.push_back(r(3, SGN, 0, !SGN));
    step();
    check("sgn_gnt", gnt, 4'b1000);
    req = '0;
    step();
    step();
    check("sgn_drained", exp_q.size(), 0);

    // Reset while FULL with req[1] held
    apply_reset();
    set_op(0, 8'h12, 8'h34);
    set_op(1, 8'h56, 8'h56);
    req       = 4'b0011;
    res_ready = 1'b0;
    step();
    check("full_gnt0", gnt, 4'b0001);
    req = 4'b0010;
    step();
    check("full_gnt1", gnt, 4'b0010);
    check("full_res_valid", res_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {gnt, res_valid, res_id, out_less, out_equal, out_more}, 0);
    res_ready = 1'b1;
    step();
    rst_n = 1'b1;
    exp_q.push_back(r(1, 0, 1, 0));
    step();
    check("post_rst_gnt", gnt, 4'b0010);
    req = '0;
    step();
    check("post_rst_res", {res_valid, res_id}, {1'b1, 2'd1});
    step();
    step();
    check("post_rst_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
